// File: rtl/cus_tag_pkg.sv
// Shared definitions for the custom-tag parser and inserter.
// Holds the byte offsets of the inserted Ethertype/tag field and the
// inserter state encoding; both blocks must agree on these constants.
package cus_tag_pkg;

   localparam int ET_OFFSET  = 12;  // byte offset of the inserted Ethertype
   localparam int ET_SIZE    = 16;  // Ethertype width in bits
   localparam int TAG_OFFSET = 14;  // byte offset of the first tag byte

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PASS,
      ST_HEAD,
      ST_BODY,
      ST_FLUSH
   } state_t;

endpackage

// File: rtl/cus_tag_byte_merge.sv
// Per-byte output mux for the tag inserter.
// For each lane j the absolute output byte position is pos + j; the lane
// takes the current input byte (before the field), a field byte (etype
// little-endian, then tag bytes), or the input byte INS positions back,
// which lives either lower in the current beat or in the held bytes.
// Ports:
//   pos    - absolute byte position of lane 0 of this output beat
//   cur    - current input beat
//   held   - trailing INS bytes of the previous input beat
//   etype  - Ethertype to insert
//   tag    - custom tag to insert
//   merged - assembled output beat
module cus_tag_byte_merge
   import cus_tag_pkg::*;
#(
   parameter int NB        = 8,
   parameter int TAG_BYTES = 6,
   parameter int PW        = 11
) (
   input  logic [PW-1:0]              pos,
   input  logic [NB-1:0][7:0]         cur,
   input  logic [TAG_BYTES+1:0][7:0]  held,
   input  logic [ET_SIZE/8-1:0][7:0]  etype,
   input  logic [TAG_BYTES-1:0][7:0]  tag,
   output logic [NB-1:0][7:0]         merged
);

   localparam int INS = 2 + TAG_BYTES;
   localparam int TIW = (TAG_BYTES > 1) ? $clog2(TAG_BYTES) : 1;

   for (genvar j = 0; j < NB; j++) begin : g_byte
      logic [7:0]     shifted;
      logic [7:0]     b;
      int             p;
      logic           ei;
      logic [TIW-1:0] ti;

      // Shifted source: input byte at position p-INS.
      if (j >= INS) begin : g_cur
         assign shifted = cur[j-INS];
      end else begin : g_held
         assign shifted = held[j];
      end

      always_comb begin
         p  = int'(pos) + j;
         ei = 1'(p - ET_OFFSET);
         ti = TIW'(p - TAG_OFFSET);
         if (p < ET_OFFSET)                   b = cur[j];
         else if (p < TAG_OFFSET)             b = etype[ei];
         else if (p < TAG_OFFSET + TAG_BYTES) b = tag[ti];
         else                                 b = shifted;
      end

      assign merged[j] = b;
   end

endmodule

// File: rtl/cus_tag_inserter.sv
// Egress custom-tag inserter.
// Inserts {Ethertype, custom tag} at byte 12 of each packet whose source ID
// has tagging enabled; other IDs and runts (<12 bytes) pass unchanged.
// One registered output stage; an extra FLUSH beat is emitted when the
// shifted tail no longer fits in the final beat.
// Ports:
//   aclk, areset          - clock, synchronous active-high reset
//   axis_in_*             - untagged input stream (tid sampled at SOP)
//   axis_out_*            - tagged output stream
//   insert_etype          - Ethertype to insert
//   has_cus_tag           - per-ID insert enable
//   custom_tags           - per-ID tag value
module cus_tag_inserter
   import cus_tag_pkg::*;
#(
   parameter int AXIS_BUS_WIDTH    = 64,
   parameter int AXIS_ID_WIDTH     = 4,
   parameter int MAX_PACKET_LENGTH = 1522,
   parameter int MAX_TAG_SIZE_BITS = 48
) (
   input  logic                                              aclk,
   input  logic                                              areset,
   input  logic [AXIS_BUS_WIDTH-1:0]                         axis_in_tdata,
   input  logic [AXIS_BUS_WIDTH/8-1:0]                       axis_in_tkeep,
   input  logic                                              axis_in_tlast,
   input  logic                                              axis_in_tvalid,
   input  logic [AXIS_ID_WIDTH-1:0]                          axis_in_tid,
   output logic                                              axis_in_tready,
   output logic [AXIS_BUS_WIDTH-1:0]                         axis_out_tdata,
   output logic [AXIS_BUS_WIDTH/8-1:0]                       axis_out_tkeep,
   output logic                                              axis_out_tlast,
   output logic                                              axis_out_tvalid,
   input  logic                                              axis_out_tready,
   input  logic [ET_SIZE-1:0]                                insert_etype,
   input  logic [2**AXIS_ID_WIDTH-1:0]                       has_cus_tag,
   input  logic [2**AXIS_ID_WIDTH-1:0][MAX_TAG_SIZE_BITS-1:0] custom_tags
);

   localparam int NB        = AXIS_BUS_WIDTH / 8;
   localparam int TAG_BYTES = MAX_TAG_SIZE_BITS / 8;
   localparam int INS       = 2 + TAG_BYTES;
   localparam int CW        = $clog2(MAX_PACKET_LENGTH + INS + 1);
   localparam int KW        = $clog2(NB + 1);
   localparam logic [CW-1:0] POS_MAX = CW'(MAX_PACKET_LENGTH + INS);

   if (INS > NB || NB < 8) begin : g_bad_cfg
      $error("cus_tag_inserter: inserted field must fit in one beat and bus must be >= 8 bytes");
   end

   function automatic int keep_count(input logic [NB-1:0] k);
      int n = 0;
      for (int i = 0; i < NB; i++) n += int'(k[i]);
      return n;
   endfunction

   function automatic logic [NB-1:0] keep_mask(input int n);
      logic [NB-1:0] m;
      for (int i = 0; i < NB; i++) m[i] = (i < n);
      return m;
   endfunction

   // Counter saturates so oversized packets keep the shifted datapath.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] b);
      return (int'(b) + NB >= int'(POS_MAX)) ? POS_MAX : b + CW'(NB);
   endfunction

   state_t                         state_q, state_d;
   logic [CW-1:0]                  pos_q, pos_d, base;
   logic [KW-1:0]                  flush_cnt_q, flush_cnt_d;
   logic [INS-1:0][7:0]            held_q;
   logic                           en_q, en_cur;
   logic [ET_SIZE-1:0]             etype_q, etype_cur;
   logic [MAX_TAG_SIZE_BITS-1:0]   tag_q, tag_cur;
   logic                           adv, in_rdy, acc, sop, runt, spill, ld;
   int                             r;
   logic [AXIS_BUS_WIDTH-1:0]      merged, nxt_data;
   logic [NB-1:0]                  nxt_keep;
   logic                           nxt_last;

   assign adv    = !axis_out_tvalid || axis_out_tready;
   assign in_rdy = adv && (state_q != ST_FLUSH) && !areset;
   assign acc    = in_rdy && axis_in_tvalid;
   assign sop    = (state_q == ST_IDLE);

   // On the SOP beat the live configuration applies; afterwards the latched copy.
   assign en_cur    = sop ? has_cus_tag[axis_in_tid] : en_q;
   assign etype_cur = sop ? insert_etype : etype_q;
   assign tag_cur   = sop ? custom_tags[axis_in_tid] : tag_q;
   assign base      = sop ? '0 : pos_q;

   assign r     = keep_count(axis_in_tkeep);
   assign runt  = (int'(base) + r) < ET_OFFSET;
   assign spill = (r + INS) > NB;

   assign axis_in_tready = in_rdy;

   cus_tag_byte_merge #(
      .NB        (NB),
      .TAG_BYTES (TAG_BYTES),
      .PW        (CW)
   ) u_merge (
      .pos    (base),
      .cur    (axis_in_tdata),
      .held   (held_q),
      .etype  (etype_cur),
      .tag    (tag_cur),
      .merged (merged)
   );

   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      flush_cnt_d = flush_cnt_q;
      ld          = 1'b0;
      nxt_data    = merged;
      nxt_keep    = '0;
      nxt_last    = 1'b0;
      case (state_q)
         ST_FLUSH: begin
            if (adv) begin
               ld       = 1'b1;
               nxt_keep = keep_mask(int'(flush_cnt_q));
               nxt_last = 1'b1;
               state_d  = ST_IDLE;
               pos_d    = '0;
            end
         end
         default: begin
            if (acc) begin
               ld    = 1'b1;
               pos_d = sat_inc(base);
               if (!en_cur) begin
                  nxt_data = axis_in_tdata;
                  nxt_keep = axis_in_tkeep;
                  nxt_last = axis_in_tlast;
                  state_d  = axis_in_tlast ? ST_IDLE : ST_PASS;
               end else if (!axis_in_tlast) begin
                  nxt_keep = axis_in_tkeep;
                  state_d  = (int'(base) + NB >= ET_OFFSET + INS) ? ST_BODY : ST_HEAD;
               end else if (runt) begin
                  // Bytes below 12 are unshifted, so the merged beat equals the input.
                  nxt_keep = axis_in_tkeep;
                  nxt_last = 1'b1;
                  state_d  = ST_IDLE;
               end else if (spill) begin
                  nxt_keep    = '1;
                  flush_cnt_d = KW'(r + INS - NB);
                  state_d     = ST_FLUSH;
               end else begin
                  nxt_keep = keep_mask(r + INS);
                  nxt_last = 1'b1;
                  state_d  = ST_IDLE;
               end
               // FLUSH still needs the next beat position.
               if (axis_in_tlast && state_d != ST_FLUSH) pos_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q         <= ST_IDLE;
         pos_q           <= '0;
         flush_cnt_q     <= '0;
         held_q          <= '0;
         en_q            <= 1'b0;
         etype_q         <= '0;
         tag_q           <= '0;
         axis_out_tdata  <= '0;
         axis_out_tkeep  <= '0;
         axis_out_tlast  <= 1'b0;
         axis_out_tvalid <= 1'b0;
      end else begin
         state_q     <= state_d;
         pos_q       <= pos_d;
         flush_cnt_q <= flush_cnt_d;
         if (acc) begin
            held_q <= axis_in_tdata[AXIS_BUS_WIDTH-1 -: 8*INS];
            if (sop) begin
               en_q    <= has_cus_tag[axis_in_tid];
               etype_q <= insert_etype;
               tag_q   <= custom_tags[axis_in_tid];
            end
         end
         if (ld) begin
            axis_out_tdata  <= nxt_data;
            axis_out_tkeep  <= nxt_keep;
            axis_out_tlast  <= nxt_last;
            axis_out_tvalid <= 1'b1;
         end else if (adv) begin
            axis_out_tvalid <= 1'b0;
         end
      end
   end

endmodule
